alarm_ring_ctrl: RTL
====================

// Module: alarm_ring_ctrl
// PURPOSE
// Downstream of the alarm comparator in the clock top level. Converts the
// alarm-match level into an audible/visible ring sequence with a beep pattern,
// a snooze counter and an automatic ring timeout. Drives the buzzer pin and
// the ring LED. Clock and time-keeping logic are unchanged.
// PARAMETERS
// SNOOZE_SEC   300  seconds between a snooze press and the next ring (>=1)
// RING_SEC     60   seconds a ring lasts before auto-stop (>=1)
// MAX_SNOOZE   3    snoozes allowed per alarm event (1..15)
// BEEP_ON      4    tick_fast periods buzzer on, per beep (>=1)
// BEEP_OFF     4    tick_fast periods buzzer off, per beep (>=1)
// PORTS
// clk          in   1   system clock; all logic on posedge
// RESET        in   1   asynchronous, active-high reset
// tick_1hz     in   1   one-clk pulse, once per second
// tick_fast    in   1   one-clk pulse, beep-pattern base rate
// alarm_en     in   1   alarm armed (level)
// alarm_hit    in   1   time==alarm match (level, may stay high >1 s)
// snooze_btn   in   1   debounced one-clk press pulse
// stop_btn     in   1   debounced one-clk press pulse
// buzzer       out  1   buzzer drive, registered
// ring_led     out  1   high while in RING or SNOOZE, registered
// snoozing     out  1   high while in SNOOZE, registered
// snooze_cnt   out  4   snoozes used in the current event
// BEHAVIOUR
// - Reset: state=IDLE; buzzer=0, ring_led=0, snoozing=0, snooze_cnt=0;
//   timers and beep phase cleared; hit_d=0.
// - Edge detect: hit_rise = alarm_hit & ~hit_d. hit_d is registered every clk.
// - FSM: IDLE, RING, SNOOZE, HOLD. Each state's outputs appear 1 clk after entry.
// - IDLE: on hit_rise & alarm_en -> RING. Ring timer=RING_SEC, beep phase=on
//   (count 0), snooze_cnt=0.
// - RING: buzzer=beep_on. Beep counter advances on tick_fast: BEEP_ON ticks on,
//   then BEEP_OFF ticks off, repeating. Ring timer decrements on tick_1hz.
//   Priority for same-cycle events: ~alarm_en > stop_btn > snooze_btn > timeout.
//   * stop_btn -> HOLD.
//   * snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE. Snooze timer=SNOOZE_SEC,
//     snooze_cnt+1. With snooze_cnt==MAX_SNOOZE the press is ignored.
//   * tick_1hz while ring timer==1 -> HOLD (timeout).
// - SNOOZE: buzzer=0. Snooze timer decrements on tick_1hz. On the tick where
//   timer==1 -> RING; ring timer reloaded, beep phase restarts on.
//   stop_btn -> HOLD. snooze_btn is ignored.
// - HOLD: all outputs 0 except snooze_cnt, which is held. When alarm_hit==0
//   -> IDLE. A held-high match therefore never re-triggers.
// - alarm_en==0 in any state -> IDLE next clk; snooze_cnt cleared.
// - Timers are saturating down-counters sized $clog2(max param + 1); they never
//   wrap below 0. snooze_cnt never exceeds MAX_SNOOZE.
// - RESET asserted mid-ring: buzzer drops asynchronously. After release the FSM
//   waits for a fresh hit_rise.
// - Latency: hit_rise to buzzer=1 is 2 clk (edge register + state register).
// TESTING (bench params SNOOZE_SEC=3, RING_SEC=5, MAX_SNOOZE=2, BEEP_ON=2,
//   BEEP_OFF=1; tick_1hz every 20 clk, tick_fast every 4 clk)
// 1 alarm_en=1, pulse alarm_hit high 30 clk -> buzzer=1 two clk after rise;
//   pattern 8 clk on / 4 clk off; ring_led=1; auto-stop after 5 tick_1hz, then IDLE.
// 2 ring, snooze_btn -> snoozing=1, buzzer=0, snooze_cnt=1; after 3 ticks ring
//   resumes; 2nd snooze -> cnt=2; 3rd snooze ignored, ringing continues.
// 3 ring, snooze_btn and stop_btn same clk -> HOLD, snooze_cnt unchanged;
//   alarm_hit held high 100 clk -> no re-ring; alarm_hit low -> IDLE.
// 4 alarm_en=0 during SNOOZE -> IDLE next clk, snooze_cnt=0, ring_led=0.
// 5 RESET pulse during RING -> buzzer=0 immediately, all outputs 0; alarm_hit
//   still high after release -> stays IDLE until next rising edge.
// 6 alarm_en=0 at hit_rise -> stays IDLE, buzzer never asserts.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: turns the alarm-match level into a beeping ring with
// snooze, stop and automatic timeout; drives the buzzer pin and ring LED.
module alarm_ring_ctrl #(
   parameter int unsigned SNOOZE_SEC = 300,
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned MAX_SNOOZE = 3,
   parameter int unsigned BEEP_ON    = 4,
   parameter int unsigned BEEP_OFF   = 4
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       tick_1hz,
   input  logic       tick_fast,
   input  logic       alarm_en,
   input  logic       alarm_hit,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       buzzer,
   output logic       ring_led,
   output logic       snoozing,
   output logic [3:0] snooze_cnt
);

   localparam int unsigned TMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned BMAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
   localparam int unsigned BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

   localparam logic [TW-1:0] RING_LD   = TW'(RING_SEC);
   localparam logic [TW-1:0] SNZ_LD    = TW'(SNOOZE_SEC);
   localparam logic [TW-1:0] TMR_ONE   = TW'(1);
   localparam logic [BW-1:0] ON_LAST   = BW'(BEEP_ON - 1);
   localparam logic [BW-1:0] OFF_LAST  = BW'(BEEP_OFF - 1);
   localparam logic [3:0]    SNZ_LIMIT = 4'(MAX_SNOOZE);

   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE, S_HOLD} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_hit_d;
   logic          r_armed;
   logic          w_hit_rise;
   logic [TW-1:0] r_ring_tmr, w_ring_tmr_nxt;
   logic [TW-1:0] r_snz_tmr, w_snz_tmr_nxt;
   logic          r_beep_on, w_beep_on_nxt;
   logic [BW-1:0] r_beep_cnt, w_beep_cnt_nxt;
   logic [3:0]    r_snooze_cnt, w_snooze_cnt_nxt;
   logic          r_buzzer, r_ring_led, r_snoozing;

   // r_armed requires alarm_hit to be seen low after reset, so a match still
   // high across a reset release does not count as a fresh rising edge.
   assign w_hit_rise = alarm_hit & ~r_hit_d & r_armed;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_ring_tmr_nxt   = r_ring_tmr;
      w_snz_tmr_nxt    = r_snz_tmr;
      w_beep_on_nxt    = r_beep_on;
      w_beep_cnt_nxt   = r_beep_cnt;
      w_snooze_cnt_nxt = r_snooze_cnt;
      case (r_state)
         S_IDLE: begin
            if (alarm_en && w_hit_rise) begin
               w_state_nxt      = S_RING;
               w_ring_tmr_nxt   = RING_LD;
               w_beep_on_nxt    = 1'b1;
               w_beep_cnt_nxt   = '0;
               w_snooze_cnt_nxt = '0;
            end
         end
         S_RING: begin
            if (tick_fast) begin
               if (r_beep_on ? (r_beep_cnt == ON_LAST) : (r_beep_cnt == OFF_LAST)) begin
                  w_beep_on_nxt  = ~r_beep_on;
                  w_beep_cnt_nxt = '0;
               end else begin
                  w_beep_cnt_nxt = r_beep_cnt + 1'b1;
               end
            end
            if (tick_1hz && (r_ring_tmr != '0))
               w_ring_tmr_nxt = r_ring_tmr - 1'b1;
            if (stop_btn) begin
               w_state_nxt = S_HOLD;
            end else if (snooze_btn && (r_snooze_cnt < SNZ_LIMIT)) begin
               w_state_nxt      = S_SNOOZE;
               w_snz_tmr_nxt    = SNZ_LD;
               w_snooze_cnt_nxt = r_snooze_cnt + 4'd1;
            end else if (tick_1hz && (r_ring_tmr == TMR_ONE)) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_SNOOZE: begin
            if (tick_1hz && (r_snz_tmr != '0))
               w_snz_tmr_nxt = r_snz_tmr - 1'b1;
            if (stop_btn) begin
               w_state_nxt = S_HOLD;
            end else if (tick_1hz && (r_snz_tmr == TMR_ONE)) begin
               w_state_nxt    = S_RING;
               w_ring_tmr_nxt = RING_LD;
               w_beep_on_nxt  = 1'b1;
               w_beep_cnt_nxt = '0;
            end
         end
         S_HOLD: begin
            if (!alarm_hit) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (!alarm_en) begin
         w_state_nxt      = S_IDLE;
         w_snooze_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_hit_d      <= 1'b0;
         r_armed      <= 1'b0;
         r_ring_tmr   <= '0;
         r_snz_tmr    <= '0;
         r_beep_on    <= 1'b0;
         r_beep_cnt   <= '0;
         r_snooze_cnt <= '0;
         r_buzzer     <= 1'b0;
         r_ring_led   <= 1'b0;
         r_snoozing   <= 1'b0;
      end else begin
         r_hit_d      <= alarm_hit;
         r_armed      <= r_armed | ~alarm_hit;
         r_ring_tmr   <= w_ring_tmr_nxt;
         r_snz_tmr    <= w_snz_tmr_nxt;
         r_beep_on    <= w_beep_on_nxt;
         r_beep_cnt   <= w_beep_cnt_nxt;
         r_snooze_cnt <= w_snooze_cnt_nxt;
         r_buzzer     <= (r_state == S_RING) & r_beep_on;
         r_ring_led   <= (r_state == S_RING) | (r_state == S_SNOOZE);
         r_snoozing   <= (r_state == S_SNOOZE);
      end
   end

   assign buzzer     = r_buzzer;
   assign ring_led   = r_ring_led;
   assign snoozing   = r_snoozing;
   assign snooze_cnt = r_snooze_cnt;

endmodule
